// File: rtl/useq_pkg.sv
// rtl/useq_pkg.sv - control-word field offsets, operation codes and flag indices for useq_ctrl
package useq_pkg;

    // Field positions are offsets below the control-word MSB so CTRL_W can grow the ALUop field.
    localparam int USRST_OFS = 1;
    localparam int PCINC_OFS = 2;
    localparam int ARENA_OFS = 3;
    localparam int JUMP_OFS  = 4;
    localparam int DBUS_OFS  = 7;
    localparam int LOAD_OFS  = 9;
    localparam int ALU_OFS   = 11;

    localparam int JUMP_W = 3;
    localparam int DBUS_W = 2;
    localparam int LOAD_W = 3;
    localparam int FLAG_W = 5;

    localparam logic [LOAD_W-1:0] LOAD_NONE = 3'd0;
    localparam logic [LOAD_W-1:0] LOAD_IR   = 3'd1;
    localparam logic [LOAD_W-1:0] LOAD_A    = 3'd2;
    localparam logic [LOAD_W-1:0] LOAD_B    = 3'd3;
    localparam logic [LOAD_W-1:0] LOAD_MEM  = 3'd4;
    localparam logic [LOAD_W-1:0] LOAD_AH   = 3'd5;
    localparam logic [LOAD_W-1:0] LOAD_AL   = 3'd6;
    localparam logic [LOAD_W-1:0] LOAD_IO   = 3'd7;

    localparam logic [DBUS_W-1:0] DBUS_MEM = 2'd0;
    localparam logic [DBUS_W-1:0] DBUS_ALU = 2'd1;

    localparam logic [JUMP_W-1:0] JMP_NEVER    = 3'd0;
    localparam logic [JUMP_W-1:0] JMP_CARRY    = 3'd1;
    localparam logic [JUMP_W-1:0] JMP_OVERFLOW = 3'd2;
    localparam logic [JUMP_W-1:0] JMP_ZERO     = 3'd3;
    localparam logic [JUMP_W-1:0] JMP_NEGATIVE = 3'd4;
    localparam logic [JUMP_W-1:0] JMP_DIVZERO  = 3'd5;
    localparam logic [JUMP_W-1:0] JMP_IO_READY = 3'd6;
    localparam logic [JUMP_W-1:0] JMP_ALWAYS   = 3'd7;

    // flags = {divzero, negative, zero, overflow, carry}
    localparam int FLAG_CARRY    = 0;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_ZERO     = 2;
    localparam int FLAG_NEGATIVE = 3;
    localparam int FLAG_DIVZERO  = 4;

endpackage

// File: rtl/useq_ctrl_if.sv
// rtl/useq_ctrl_if.sv - bus bundle between useq_ctrl and its ROM/ALU/memory/UART; mem_ready only with USEQ_WAIT_EN
interface useq_ctrl_if #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int USTEP_W = 4,
    parameter int CTRL_W  = 16
);
    logic [DATA_W-1:0]         databus;
    logic [CTRL_W-1:0]         ctrl_word;
    logic [4:0]                flags;
    logic                      io_ready;
`ifdef USEQ_WAIT_EN
    logic                      mem_ready;
`endif
    logic [DATA_W+USTEP_W-1:0] uaddr;
    logic [ADDR_W-1:0]         pc;
    logic [ADDR_W-1:0]         addressbus;
    logic                      mem_oe_n;
    logic                      alu_oe_n;
    logic                      mem_we_n;
    logic                      io_we_n;
    logic [CTRL_W-12:0]        aluop;

    modport master (
        input  databus, ctrl_word, flags, io_ready,
`ifdef USEQ_WAIT_EN
        input  mem_ready,
`endif
        output uaddr, pc, addressbus, mem_oe_n, alu_oe_n, mem_we_n, io_we_n, aluop
    );

    modport slave (
        output databus, ctrl_word, flags, io_ready,
`ifdef USEQ_WAIT_EN
        output mem_ready,
`endif
        input  uaddr, pc, addressbus, mem_oe_n, alu_oe_n, mem_we_n, io_we_n, aluop
    );
endinterface

// File: rtl/useq_jump_mux.sv
// rtl/useq_jump_mux.sv - 8:1 jump-condition select {always, io_ready, flags, never} by JumpOp
module useq_jump_mux
    import useq_pkg::*;
(
    input  logic [JUMP_W-1:0] jump_op,
    input  logic [FLAG_W-1:0] flags,
    input  logic              io_ready,
    output logic              jump_taken
);
    always_comb begin
        jump_taken = 1'b0;
        case (jump_op)
            JMP_NEVER:    jump_taken = 1'b0;
            JMP_CARRY:    jump_taken = flags[FLAG_CARRY];
            JMP_OVERFLOW: jump_taken = flags[FLAG_OVERFLOW];
            JMP_ZERO:     jump_taken = flags[FLAG_ZERO];
            JMP_NEGATIVE: jump_taken = flags[FLAG_NEGATIVE];
            JMP_DIVZERO:  jump_taken = flags[FLAG_DIVZERO];
            JMP_IO_READY: jump_taken = io_ready;
            JMP_ALWAYS:   jump_taken = 1'b1;
            default:      jump_taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/useq_ctrl.sv
// rtl/useq_ctrl.sv - microcoded control unit: IR, microstep, PC, AH/AL and strobes; USEQ_WAIT_EN adds memory wait states
module useq_ctrl
    import useq_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int USTEP_W = 4,
    parameter int CTRL_W  = 16
) (
    input  logic        i_clk,
    input  logic        reset,
    useq_ctrl_if.master bus
);
    localparam int ALU_W = CTRL_W - ALU_OFS;

    logic              us_rst_n;
    logic              pc_incr;
    logic              ar_ena_n;
    logic [JUMP_W-1:0] jump_op;
    logic [DBUS_W-1:0] dbus_op;
    logic [LOAD_W-1:0] load_op;
    logic [ALU_W-1:0]  alu_field;

    logic [DATA_W-1:0]  ir;
    logic [DATA_W-1:0]  ah;
    logic [DATA_W-1:0]  al;
    logic [USTEP_W-1:0] ustep;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  ar;

    logic jump_taken;
    logic mem_ready_int;
    logic mem_access;
    logic stall;

    assign us_rst_n  = bus.ctrl_word[CTRL_W-USRST_OFS];
    assign pc_incr   = bus.ctrl_word[CTRL_W-PCINC_OFS];
    assign ar_ena_n  = bus.ctrl_word[CTRL_W-ARENA_OFS];
    assign jump_op   = bus.ctrl_word[CTRL_W-JUMP_OFS -: JUMP_W];
    assign dbus_op   = bus.ctrl_word[CTRL_W-DBUS_OFS -: DBUS_W];
    assign load_op   = bus.ctrl_word[CTRL_W-LOAD_OFS -: LOAD_W];
    assign alu_field = bus.ctrl_word[ALU_W-1:0];

    assign ar = {ah, al};

`ifdef USEQ_WAIT_EN
    assign mem_ready_int = bus.mem_ready;
`else
    assign mem_ready_int = 1'b1;
`endif

    // A memory read or write without ready freezes all state; strobes stay asserted because ctrl_word is held.
    assign mem_access = (dbus_op == DBUS_MEM) || (load_op == LOAD_MEM);
    assign stall      = mem_access && !mem_ready_int;

    useq_jump_mux u_jump_mux (
        .jump_op    (jump_op),
        .flags      (bus.flags),
        .io_ready   (bus.io_ready),
        .jump_taken (jump_taken)
    );

    always_ff @(posedge i_clk) begin
        if (reset) begin
            ir    <= '0;
            ustep <= '0;
            ah    <= '0;
            al    <= '0;
            pc_q  <= '0;
        end else if (!stall) begin
            ustep <= us_rst_n ? ustep + USTEP_W'(1) : '0;

            case (load_op)
                LOAD_IR: ir <= bus.databus;
                LOAD_AH: ah <= bus.databus;
                LOAD_AL: al <= bus.databus;
                LOAD_NONE, LOAD_A, LOAD_B, LOAD_MEM, LOAD_IO: ;
                default: ;
            endcase

            // A taken jump suppresses the increment requested in the same word.
            if (jump_taken) begin
                pc_q <= ar;
            end else if (pc_incr) begin
                pc_q <= pc_q + ADDR_W'(1);
            end
        end
    end

    assign bus.uaddr      = {ir, ustep};
    assign bus.pc         = pc_q;
    assign bus.addressbus = ar_ena_n ? pc_q : ar;
    assign bus.mem_oe_n   = (dbus_op != DBUS_MEM);
    assign bus.alu_oe_n   = (dbus_op != DBUS_ALU);
    assign bus.mem_we_n   = (load_op != LOAD_MEM);
    assign bus.io_we_n    = (load_op != LOAD_IO);
    assign bus.aluop      = alu_field;

endmodule

// File: tb/tb_useq_ctrl.sv
// tb/tb_useq_ctrl.sv - directed vector bench for useq_ctrl; wait-state sequence runs when USEQ_WAIT_EN is defined
module tb_useq_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    useq_ctrl_if bus ();

    useq_ctrl dut (
        .i_clk (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] cw;
        logic [7:0]  db;
        logic [4:0]  fl;
        logic        io;
        logic [15:0] exp_ab;
        logic [3:0]  exp_strb;
        logic [4:0]  exp_alu;
        logic [11:0] exp_uaddr;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs [19];

    function automatic logic [15:0] cw(input logic usr_n, input logic pci, input logic arn,
                                       input logic [2:0] jmp, input logic [1:0] dbus,
                                       input logic [2:0] load, input logic [4:0] alu);
        return {usr_n, pci, arn, jmp, dbus, load, alu};
    endfunction

    function automatic vec_t mk(input logic [15:0] c, input logic [7:0] d, input logic [4:0] f,
                                input logic i, input logic [15:0] ab, input logic [3:0] s,
                                input logic [4:0] a, input logic [11:0] u, input logic [15:0] p);
        vec_t v;
        v.cw = c; v.db = d; v.fl = f; v.io = i;
        v.exp_ab = ab; v.exp_strb = s; v.exp_alu = a; v.exp_uaddr = u; v.exp_pc = p;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [15:0] c, input logic [7:0] d);
        @(negedge clk);
        reset = 1'b0;
        bus.ctrl_word = c;
        bus.databus = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] state_w();
        return {4'h0, bus.uaddr, bus.pc};
    endfunction

    function automatic logic [31:0] comb_w();
        return {7'h0, bus.addressbus, bus.mem_oe_n, bus.alu_oe_n, bus.mem_we_n, bus.io_we_n, bus.aluop};
    endfunction

    initial begin
        // strobes column = {mem_oe_n, alu_oe_n, mem_we_n, io_we_n}
        vecs[0]  = mk(cw(1,0,1,0,2,5,0),     8'h12, 5'b00000, 0, 16'h0000, 4'b1111, 5'h00, 12'h001, 16'h0000);
        vecs[1]  = mk(cw(1,0,0,0,2,6,0),     8'h34, 5'b00000, 0, 16'h1200, 4'b1111, 5'h00, 12'h002, 16'h0000);
        vecs[2]  = mk(cw(1,1,0,7,2,0,0),     8'h00, 5'b00000, 0, 16'h1234, 4'b1111, 5'h00, 12'h003, 16'h1234);
        vecs[3]  = mk(cw(1,1,1,3,0,0,0),     8'h00, 5'b11011, 0, 16'h1234, 4'b0111, 5'h00, 12'h004, 16'h1235);
        vecs[4]  = mk(cw(1,1,1,3,1,0,0),     8'h00, 5'b00100, 0, 16'h1235, 4'b1011, 5'h00, 12'h005, 16'h1234);
        vecs[5]  = mk(cw(1,0,1,6,2,7,0),     8'h00, 5'b11111, 0, 16'h1234, 4'b1110, 5'h00, 12'h006, 16'h1234);
        vecs[6]  = mk(cw(1,1,1,1,2,4,5'h15), 8'h00, 5'b11110, 1, 16'h1234, 4'b1101, 5'h15, 12'h007, 16'h1235);
        vecs[7]  = mk(cw(1,0,1,0,2,5,0),     8'hFF, 5'b00000, 0, 16'h1235, 4'b1111, 5'h00, 12'h008, 16'h1235);
        vecs[8]  = mk(cw(1,0,1,0,2,6,0),     8'hFF, 5'b00000, 0, 16'h1235, 4'b1111, 5'h00, 12'h009, 16'h1235);
        vecs[9]  = mk(cw(1,0,1,6,2,0,5'h0A), 8'h00, 5'b00000, 1, 16'h1235, 4'b1111, 5'h0A, 12'h00A, 16'hFFFF);
        vecs[10] = mk(cw(1,1,1,0,2,0,0),     8'h00, 5'b00000, 0, 16'hFFFF, 4'b1111, 5'h00, 12'h00B, 16'h0000);
        vecs[11] = mk(cw(1,0,1,5,2,0,0),     8'h00, 5'b10000, 0, 16'h0000, 4'b1111, 5'h00, 12'h00C, 16'hFFFF);
        vecs[12] = mk(cw(1,1,1,2,2,0,0),     8'h00, 5'b11101, 1, 16'hFFFF, 4'b1111, 5'h00, 12'h00D, 16'h0000);
        vecs[13] = mk(cw(1,0,1,0,2,0,0),     8'h00, 5'b11111, 1, 16'h0000, 4'b1111, 5'h00, 12'h00E, 16'h0000);
        vecs[14] = mk(cw(1,0,1,0,3,0,0),     8'h00, 5'b00000, 0, 16'h0000, 4'b1111, 5'h00, 12'h00F, 16'h0000);
        vecs[15] = mk(cw(1,0,1,0,2,0,0),     8'h00, 5'b00000, 0, 16'h0000, 4'b1111, 5'h00, 12'h000, 16'h0000);
        vecs[16] = mk(cw(0,0,1,0,2,1,0),     8'hA5, 5'b00000, 0, 16'h0000, 4'b1111, 5'h00, 12'hA50, 16'h0000);
        vecs[17] = mk(cw(1,0,1,0,2,0,0),     8'h00, 5'b00000, 0, 16'h0000, 4'b1111, 5'h00, 12'hA51, 16'h0000);
        vecs[18] = mk(cw(1,0,1,4,2,0,0),     8'h00, 5'b01000, 0, 16'h0000, 4'b1111, 5'h00, 12'hA52, 16'hFFFF);

        reset = 1'b1;
        bus.ctrl_word = cw(1,0,1,0,2,0,0);
        bus.databus = 8'h00;
        bus.flags = 5'b00000;
        bus.io_ready = 1'b0;
`ifdef USEQ_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", state_w(), {4'h0, 12'h000, 16'h0000});

        step(cw(1,0,1,5,2,5,0) & 16'hE3FF, 8'h12);
        step(cw(1,0,1,0,2,6,0), 8'h34);
        step(cw(1,0,1,7,2,0,0), 8'h00);
        step(cw(1,0,1,0,2,0,0), 8'h00);
        step(cw(1,0,1,0,2,0,0), 8'h00);
        check("pre_reset_state", state_w(), {4'h0, 12'h005, 16'h1234});

        @(negedge clk);
        reset = 1'b1;
        bus.ctrl_word = cw(1,1,1,7,2,1,0);
        bus.databus = 8'hFF;
        @(posedge clk);
        #1;
        check("reset_override", state_w(), {4'h0, 12'h000, 16'h0000});

        step(cw(1,0,1,7,2,0,0), 8'h00);
        check("reset_clears_ar", state_w(), {4'h0, 12'h001, 16'h0000});

        @(negedge clk);
        reset = 1'b1;
        bus.ctrl_word = cw(1,0,1,0,2,0,0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            reset = 1'b0;
            bus.ctrl_word = vecs[i].cw;
            bus.databus = vecs[i].db;
            bus.flags = vecs[i].fl;
            bus.io_ready = vecs[i].io;
            #1;
            check($sformatf("vec%0d_comb", i), comb_w(),
                  {7'h0, vecs[i].exp_ab, vecs[i].exp_strb, vecs[i].exp_alu});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_state", i), state_w(), {4'h0, vecs[i].exp_uaddr, vecs[i].exp_pc});
        end

`ifdef USEQ_WAIT_EN
        @(negedge clk);
        bus.ctrl_word = cw(1,1,1,0,0,0,0);
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_hold", k), state_w(), {4'h0, 12'hA52, 16'hFFFF});
            check($sformatf("stall%0d_oe", k), {31'h0, bus.mem_oe_n}, 32'h0);
        end
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        check("ready_oe", {31'h0, bus.mem_oe_n}, 32'h0);
        @(posedge clk);
        #1;
        check("ready_advance", state_w(), {4'h0, 12'hA53, 16'h0000});

        @(negedge clk);
        bus.ctrl_word = cw(1,1,1,0,2,4,0);
        bus.mem_ready = 1'b0;
        #1;
        check("write_stall_we", {31'h0, bus.mem_we_n}, 32'h0);
        @(posedge clk);
        #1;
        check("write_stall_hold", state_w(), {4'h0, 12'hA53, 16'h0000});
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_over_stall", state_w(), {4'h0, 12'h000, 16'h0000});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
